// File: rtl/pn_sync_checker.sv
// pn_sync_checker
//   Receive-side checker for the serial output of the programmable LFSR
//   generator. Loads a local replica from the incoming bits, verifies it
//   against the stream, declares lock, then counts bit errors. Lock is
//   dropped and the replica reloaded when too many errors land in one window.
//
// Ports
//   next       clock, one rising edge per potential received bit
//   reset      asynchronous active-low reset
//   enable     run when high, return to IDLE when low
//   N          sequence length, valid 2..13
//   char_poly  feedback tap mask (bit i -> replica bit i enters parity)
//   bit_valid  qualifies bit_in
//   bit_in     received PN bit
//   clear      zeroes err_count and bit_count
//   locked     high while in LOCKED
//   err_pulse  one-cycle pulse per mismatched bit in LOCKED
//   err_count  saturating mismatch count (LOCKED only)
//   bit_count  saturating checked-bit count (LOCKED only)
//   cfg_err    enable high with N outside 2..13
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for enable with a legal N; latches N and poly
// S_LOAD   | shifting N received bits straight into the replica
// S_VERIFY | free-running replica, needs LOCK_CNT consecutive matches
// S_LOCKED | checking and counting errors over WIN-bit windows
module pn_sync_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int WIN        = 64,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             next,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       N,
    input  logic [12:0]      char_poly,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic             cfg_err
);

    localparam int MW = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT)   : 1;
    localparam int WW = (WIN        > 1) ? $clog2(WIN)        : 1;
    localparam int EW = (ERR_THRESH > 1) ? $clog2(ERR_THRESH) : 1;

    // Down-counter reload values; terminal count is zero.
    localparam logic [MW-1:0] MATCH_TC = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_TC   = WW'(WIN - 1);
    localparam logic [EW-1:0] ERR_TC   = EW'(ERR_THRESH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [12:0]      r, r_nxt;
    logic [12:0]      poly_q, poly_nxt;
    logic [3:0]       n_q, n_nxt;
    logic [3:0]       ld_left, ld_nxt;
    logic [MW-1:0]    match_left, match_nxt;
    logic [WW-1:0]    win_left, win_nxt;
    logic [EW-1:0]    err_left, errw_nxt;
    logic [CNT_W-1:0] ec_nxt, bc_nxt;
    logic             pulse_nxt, cfg_nxt;

    logic             n_ok;
    logic             p;
    logic             mism;
    logic [12:0]      r_shift_in;
    logic [12:0]      r_step;

    assign n_ok = (N >= 4'd2) && (N <= 4'd13);
    assign p    = ^(r & poly_q);
    assign mism = bit_in ^ p;

    // New bit enters at r[N-1]; bits above N-1 stay zero because r>>1
    // never moves anything up.
    assign r_shift_in = (r >> 1) | ({12'b0, bit_in} << (n_q - 4'd1));
    assign r_step     = (r >> 1) | ({12'b0, p}      << (n_q - 4'd1));

    // State register
    always_ff @(posedge next or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (n_ok) state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    // An all-zero replica would predict zeros forever, so a
                    // stuck-0 line must never reach VERIFY.
                    if (bit_valid && (ld_left == 4'd0) && (r_shift_in != 13'd0))
                        state_nxt = S_VERIFY;
                end
                S_VERIFY: begin
                    if (bit_valid) begin
                        if (mism)
                            state_nxt = S_LOAD;
                        else if (match_left == '0)
                            state_nxt = S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (bit_valid && mism && (err_left == '0))
                        state_nxt = S_LOAD;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        r_nxt     = r;
        poly_nxt  = poly_q;
        n_nxt     = n_q;
        ld_nxt    = ld_left;
        match_nxt = match_left;
        win_nxt   = win_left;
        errw_nxt  = err_left;
        ec_nxt    = err_count;
        bc_nxt    = bit_count;
        pulse_nxt = 1'b0;
        cfg_nxt   = enable && !n_ok;

        if (enable) begin
            case (state)
                S_IDLE: begin
                    if (n_ok) begin
                        r_nxt    = 13'd0;
                        poly_nxt = char_poly & ~(13'h1FFF << N);
                        n_nxt    = N;
                        ld_nxt   = N - 4'd1;
                    end
                end
                S_LOAD: begin
                    if (bit_valid) begin
                        r_nxt = r_shift_in;
                        if (ld_left == 4'd0) begin
                            ld_nxt    = n_q - 4'd1;
                            match_nxt = MATCH_TC;
                        end else begin
                            ld_nxt = ld_left - 4'd1;
                        end
                    end
                end
                S_VERIFY: begin
                    if (bit_valid) begin
                        r_nxt = r_step;
                        if (mism) begin
                            ld_nxt = n_q - 4'd1;
                        end else if (match_left == '0) begin
                            win_nxt  = WIN_TC;
                            errw_nxt = ERR_TC;
                        end else begin
                            match_nxt = match_left - 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (bit_valid) begin
                        r_nxt  = r_step;
                        bc_nxt = bit_count + CNT_W'(bit_count != '1);
                        if (mism) begin
                            ec_nxt    = err_count + CNT_W'(err_count != '1);
                            pulse_nxt = 1'b1;
                        end
                        // Threshold hit takes priority over the window wrap.
                        if (mism && (err_left == '0)) begin
                            ld_nxt = n_q - 4'd1;
                        end else if (win_left == '0) begin
                            win_nxt  = WIN_TC;
                            errw_nxt = ERR_TC;
                        end else begin
                            win_nxt = win_left - 1'b1;
                            if (mism) errw_nxt = err_left - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (clear) begin
            ec_nxt = '0;
            bc_nxt = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge next or negedge reset) begin
        if (!reset) begin
            r          <= 13'd0;
            poly_q     <= 13'd0;
            n_q        <= 4'd0;
            ld_left    <= 4'd0;
            match_left <= '0;
            win_left   <= '0;
            err_left   <= '0;
            err_count  <= '0;
            bit_count  <= '0;
            err_pulse  <= 1'b0;
            cfg_err    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            r          <= r_nxt;
            poly_q     <= poly_nxt;
            n_q        <= n_nxt;
            ld_left    <= ld_nxt;
            match_left <= match_nxt;
            win_left   <= win_nxt;
            err_left   <= errw_nxt;
            err_count  <= ec_nxt;
            bit_count  <= bc_nxt;
            err_pulse  <= pulse_nxt;
            cfg_err    <= cfg_nxt;
            locked     <= (state_nxt == S_LOCKED);
        end
    end

endmodule

// File: tb/tb_pn_sync_checker.sv
// tb_pn_sync_checker
//   Scoreboard bench: each driven edge runs a behavioural checker model and
//   pushes its expected outputs; the value is popped and compared just
//   after the edge. Scenario-level expectations are checked as constants.
module tb_pn_sync_checker;

    localparam int CNT_W = 16;

    logic             next = 1'b0;
    logic             reset;
    logic             enable;
    logic [3:0]       N;
    logic [12:0]      char_poly;
    logic             bit_valid;
    logic             bit_in;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic             cfg_err;

    pn_sync_checker #(
        .LOCK_CNT(16), .WIN(64), .ERR_THRESH(8), .CNT_W(CNT_W)
    ) dut (
        .next(next), .reset(reset), .enable(enable), .N(N),
        .char_poly(char_poly), .bit_valid(bit_valid), .bit_in(bit_in),
        .clear(clear), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .bit_count(bit_count), .cfg_err(cfg_err)
    );

    always #5 next = ~next;

    int checks   = 0;
    int failures = 0;
    int n_pulse  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_st;   // 0 idle, 1 load, 2 verify, 3 locked
    int               m_n, m_lc, m_mc, m_wb, m_we;
    logic [12:0]      m_r, m_poly;
    logic             m_locked, m_pulse, m_cfg;
    logic [CNT_W-1:0] m_ec, m_bc;
    logic [34:0]      exp_q[$];

    function automatic logic [12:0] shift_in(input logic [12:0] r, input int n, input logic b);
        logic [12:0] nr;
        nr = 13'd0;
        for (int i = 0; i < n - 1; i++) nr[i] = r[i+1];
        nr[n-1] = b;
        return nr;
    endfunction

    task automatic model_reset();
        m_st = 0; m_n = 0; m_lc = 0; m_mc = 0; m_wb = 0; m_we = 0;
        m_r = 13'd0; m_poly = 13'd0;
        m_locked = 1'b0; m_pulse = 1'b0; m_cfg = 1'b0;
        m_ec = '0; m_bc = '0;
    endtask

    task automatic model_edge();
        logic p, mis;
        m_pulse = 1'b0;
        m_cfg   = enable && (N < 4'd2 || N > 4'd13);
        p   = ^(m_r & m_poly);
        mis = (bit_in != p);
        if (!enable) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (N >= 4'd2 && N <= 4'd13) begin
                    m_st = 1; m_n = int'(N); m_r = 13'd0; m_lc = 0;
                    m_poly = char_poly & 13'((1 << int'(N)) - 1);
                end
                1: if (bit_valid) begin
                    m_r = shift_in(m_r, m_n, bit_in);
                    m_lc++;
                    if (m_lc == m_n) begin
                        m_lc = 0;
                        if (m_r != 13'd0) begin m_st = 2; m_mc = 0; end
                    end
                end
                2: if (bit_valid) begin
                    if (!mis) begin
                        m_r = shift_in(m_r, m_n, p);
                        m_mc++;
                        if (m_mc == 16) begin m_st = 3; m_wb = 0; m_we = 0; end
                    end else begin
                        m_st = 1; m_lc = 0;
                    end
                end
                default: if (bit_valid) begin
                    m_r = shift_in(m_r, m_n, p);
                    if (m_bc != '1) m_bc++;
                    m_wb++;
                    if (mis) begin
                        if (m_ec != '1) m_ec++;
                        m_we++;
                        m_pulse = 1'b1;
                    end
                    if (m_we == 8) begin
                        m_st = 1; m_lc = 0;
                    end else if (m_wb == 64) begin
                        m_wb = 0; m_we = 0;
                    end
                end
            endcase
        end
        if (clear) begin m_ec = '0; m_bc = '0; end
        m_locked = (m_st == 3);
    endtask

    // ---------------- reference generator ----------------
    logic [12:0] g_reg, g_poly;
    int          g_n;

    task automatic gen_init(input int n, input logic [12:0] poly);
        g_n = n; g_poly = poly; g_reg = 13'd1;
    endtask

    task automatic gen_step(output logic b);
        logic fb;
        b  = g_reg[0];
        fb = ^(g_reg & g_poly);
        g_reg = shift_in(g_reg, g_n, fb);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic v, input logic b, input logic clr);
        logic [34:0] e, o;
        bit_valid = v; bit_in = b; clear = clr;
        model_edge();
        exp_q.push_back({m_locked, m_pulse, m_cfg, m_ec, m_bc});
        @(posedge next);
        #1;
        o = {locked, err_pulse, cfg_err, err_count, bit_count};
        if (err_pulse === 1'b1) n_pulse++;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("sb", 64'(o), 64'(e));
        end
    endtask

    task automatic clean_bit();
        logic b;
        gen_step(b);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic bad_bit(input logic clr);
        logic b;
        gen_step(b);
        drive(1'b1, ~b, clr);
    endtask

    task automatic start(input logic [3:0] n, input logic [12:0] poly);
        enable = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        N = n; char_poly = poly; enable = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        gen_init(int'(n), poly);
    endtask

    task automatic run_to_lock(input int max_bits, input bit toggle, output int at);
        logic b;
        int   k;
        k  = 0;
        at = -1;
        for (int i = 0; i < max_bits && at < 0; i++) begin
            if (toggle) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            gen_step(b);
            drive(1'b1, b, 1'b0);
            k++;
            if (locked === 1'b1) at = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   at;
        logic stuck_lock;

        reset = 1'b0; enable = 1'b0; N = 4'd4; char_poly = 13'h0009;
        bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
        model_reset();
        #12;
        chk("reset_out", 64'({locked, err_pulse, cfg_err, err_count, bit_count}), 64'd0);
        reset = 1'b1;

        // Clean lock, N=4
        start(4'd4, 13'h0009);
        run_to_lock(40, 1'b0, at);
        chk("lock_n4", 64'(at), 64'd20);
        n_pulse = 0;
        repeat (100) clean_bit();
        chk("clean_errs",   64'(err_count), 64'd0);
        chk("clean_bits",   64'(bit_count), 64'd100);
        chk("clean_pulses", 64'(n_pulse),   64'd0);

        // Single error at locked-phase bit 130 (bit 30 after the clean run)
        repeat (29) clean_bit();
        bad_bit(1'b0);
        chk("single_pulse", 64'(err_pulse), 64'd1);
        clean_bit();
        chk("single_pulse_end", 64'(err_pulse), 64'd0);
        repeat (69) clean_bit();
        chk("single_errs",   64'(err_count), 64'd1);
        chk("single_locked", 64'(locked),    64'd1);
        chk("single_pulses", 64'(n_pulse),   64'd1);

        // Burst of 8 inside a fresh window (locked bits 201..208)
        drive(1'b0, 1'b0, 1'b1);
        chk("clear_idle", 64'({err_count, bit_count}), 64'd0);
        repeat (7) bad_bit(1'b0);
        chk("burst_hold", 64'(locked), 64'd1);
        bad_bit(1'b0);
        chk("burst_drop", 64'(locked),    64'd0);
        chk("burst_errs", 64'(err_count), 64'd8);
        chk("burst_bits", 64'(bit_count), 64'd8);
        run_to_lock(40, 1'b0, at);
        chk("relock",     64'(at),        64'd20);
        chk("bc_held",    64'(bit_count), 64'd8);
        repeat (5) clean_bit();
        chk("bc_resume",  64'(bit_count), 64'd13);

        // Stuck-0 line
        enable = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        enable = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        stuck_lock = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            stuck_lock = stuck_lock | locked;
        end
        chk("stuck_lock", 64'(stuck_lock), 64'd0);
        chk("stuck_cnts", 64'({err_count, bit_count}), 64'd0);

        // Gapped stream
        start(4'd4, 13'h0009);
        run_to_lock(60, 1'b1, at);
        chk("lock_gaps", 64'(at), 64'd20);

        // Config errors
        enable = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        N = 4'd1; enable = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("cfg_n1",     64'(cfg_err), 64'd1);
        chk("cfg_n1_lck", 64'(locked),  64'd0);
        N = 4'd14;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("cfg_n14",    64'(cfg_err), 64'd1);
        N = 4'd13; char_poly = 13'h001B;
        drive(1'b0, 1'b0, 1'b0);
        chk("cfg_ok", 64'(cfg_err), 64'd0);
        gen_init(13, 13'h001B);
        run_to_lock(60, 1'b0, at);
        chk("lock_n13", 64'(at), 64'd29);

        // Clear on an erroneous bit
        repeat (3) clean_bit();
        bad_bit(1'b1);
        chk("clear_err", 64'(err_count), 64'd0);
        repeat (3) clean_bit();
        chk("clear_lck", 64'(locked), 64'd1);

        // Asynchronous reset mid-lock
        #2;
        reset = 1'b0;
        #1;
        chk("reset_mid", 64'({locked, err_pulse, cfg_err, err_count, bit_count}), 64'd0);
        model_reset();
        exp_q.delete();
        #1;
        reset = 1'b1;
        N = 4'd4; char_poly = 13'h0009;
        drive(1'b0, 1'b0, 1'b0);
        gen_init(4, 13'h0009);
        run_to_lock(40, 1'b0, at);
        chk("relock_rst", 64'(at), 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
